datapath_unpack_fifo: RTL and testbench

Return-path width converter and buffer for the datapath. It accepts 192-bit entries, one per write strobe, and stores them in a DEPTH-entry buffer. It emits each entry as two 128-bit beats on a valid/ready stream toward the host/DMA side. The beat split is the exact inverse of the datapath's 128->192 packing: beat 0 carries entry[127:0]; beat 1 carries entry[191:128] in its low 64 bits.

---
 rtl/datapath_unpack_fifo_if.sv | 44 ++++
 rtl/datapath_unpack_fifo.sv | 170 +++++++++++++++++
 tb/tb_datapath_unpack_fifo.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_unpack_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_unpack_fifo_if
//  Description : Bundles the write side, status flags and the 128-bit
//                valid/ready beat stream of datapath_unpack_fifo.
//                master : the FIFO itself (drives status and beat stream)
//                slave  : the surrounding logic (drives writes and m_ready)
//  Ports       : wr, data_in            - entry write strobe / payload
//                full, empty, threshold - occupancy flags
//                overflow, data_count   - sticky drop flag / entry count
//                m_valid, m_ready,      - beat stream handshake
//                m_data, m_last         - beat payload / second-beat marker
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_unpack_fifo_if #(
    parameter int INPUT_DATA_WIDTH  = 192,
    parameter int OUTPUT_DATA_WIDTH = 128,
    parameter int DEPTH_SIZE        = 10
);
    logic                          wr;
    logic [INPUT_DATA_WIDTH-1:0]   data_in;
    logic                          full;
    logic                          empty;
    logic                          threshold;
    logic                          overflow;
    logic [DEPTH_SIZE:0]           data_count;
    logic                          m_valid;
    logic                          m_ready;
    logic [OUTPUT_DATA_WIDTH-1:0]  m_data;
    logic                          m_last;

    modport master (
        input  wr, data_in, m_ready,
        output full, empty, threshold, overflow, data_count,
        output m_valid, m_data, m_last
    );

    modport slave (
        output wr, data_in, m_ready,
        input  full, empty, threshold, overflow, data_count,
        input  m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/datapath_unpack_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_unpack_fifo
//  Description : Buffers 192-bit entries in a DEPTH-deep memory and emits each
//                one as two 128-bit beats: beat 0 = entry[127:0], beat 1 =
//                {64'h0, entry[191:128]} with m_last set.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - datapath_unpack_fifo_if.master (write side, flags,
//                       beat stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_unpack_fifo #(
    parameter int INPUT_DATA_WIDTH  = 192,
    parameter int OUTPUT_DATA_WIDTH = 128,
    parameter int DEPTH             = 1024,
    parameter int DEPTH_SIZE        = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    datapath_unpack_fifo_if.master bus
);

    localparam int PTR_W = DEPTH_SIZE + 1;
    // Zero padding above the upper 64-bit lane in beat 1.
    localparam int PAD_W = 2 * OUTPUT_DATA_WIDTH - INPUT_DATA_WIDTH;
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    logic [INPUT_DATA_WIDTH-1:0]  mem [DEPTH];

    logic [PTR_W-1:0]             w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0]             r_ptr_q, r_ptr_d;
    state_t                       state_q, state_d;
    logic                         m_valid_q, m_valid_d;
    logic                         m_last_q, m_last_d;
    logic [OUTPUT_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [INPUT_DATA_WIDTH-1:0]  out_entry_q, out_entry_d;
    logic                         overflow_q, overflow_d;

    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;
    logic [PTR_W-1:0]             w_count;
    logic [INPUT_DATA_WIDTH-1:0]  w_head;

    // Extra wrap bit distinguishes full (MSBs differ) from empty (MSBs equal).
    assign w_full  = (w_ptr_q[DEPTH_SIZE] != r_ptr_q[DEPTH_SIZE]) &&
                     (w_ptr_q[DEPTH_SIZE-1:0] == r_ptr_q[DEPTH_SIZE-1:0]);
    assign w_empty = (w_ptr_q == r_ptr_q);
    assign w_count = w_ptr_q - r_ptr_q;
    assign w_push  = bus.wr && !w_full;
    assign w_head  = mem[r_ptr_q[DEPTH_SIZE-1:0]];

    // Write side: a write into a full buffer is dropped and latched sticky.
    always_comb begin
        w_ptr_d    = w_ptr_q;
        overflow_d = overflow_q;
        if (w_push) begin
            w_ptr_d = w_ptr_q + c_ptr_one;
        end
        if (bus.wr && w_full) begin
            overflow_d = 1'b1;
        end
    end

    // Beat FSM. Outputs are registered, so each branch computes the beat
    // that will be presented after the edge.
    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        out_entry_d = out_entry_q;
        w_pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    state_d   = BEAT0;
                end
            end
            BEAT0: begin
                if (bus.m_ready) begin
                    state_d   = BEAT1;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    m_data_d  = {{PAD_W{1'b0}},
                                 out_entry_q[INPUT_DATA_WIDTH-1:OUTPUT_DATA_WIDTH]};
                end
            end
            BEAT1: begin
                if (bus.m_ready) begin
                    if (!w_empty) begin
                        // Back-to-back: next entry's first beat follows at once.
                        w_pop   = 1'b1;
                        state_d = BEAT0;
                    end else begin
                        state_d   = IDLE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase

        if (w_pop) begin
            out_entry_d = w_head;
            m_valid_d   = 1'b1;
            m_last_d    = 1'b0;
            m_data_d    = w_head[OUTPUT_DATA_WIDTH-1:0];
        end
    end

    assign r_ptr_d = w_pop ? (r_ptr_q + c_ptr_one) : r_ptr_q;

    // Storage is not reset; only pointers define which words are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem[w_ptr_q[DEPTH_SIZE-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            out_entry_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            out_entry_q <= out_entry_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.data_count = w_count;
    assign bus.threshold  = w_count[DEPTH_SIZE] | w_count[DEPTH_SIZE-1];
    assign bus.overflow   = overflow_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_last     = m_last_q;
    assign bus.m_data     = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_unpack_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_unpack_fifo
//  Description : Randomized self-checking bench for datapath_unpack_fifo with
//                a queue-based reference model of buffer and output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_unpack_fifo;

    localparam int DEPTH = 1024;
    localparam int DS    = 10;
    localparam int IW    = 192;
    localparam int OW    = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_unpack_fifo_if #(
        .INPUT_DATA_WIDTH (IW),
        .OUTPUT_DATA_WIDTH(OW),
        .DEPTH_SIZE       (DS)
    ) bus ();

    datapath_unpack_fifo #(
        .INPUT_DATA_WIDTH (IW),
        .OUTPUT_DATA_WIDTH(OW),
        .DEPTH            (DEPTH),
        .DEPTH_SIZE       (DS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: queued entries, entry in the output stage and how many
    // of its beats are still to be delivered.
    logic [IW-1:0] mq[$];
    logic [IW-1:0] cur;
    int            beats_left;
    bit            ovf_m;
    int            n_beats;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [IW-1:0] rand_entry();
        logic [IW-1:0] v;
        for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        chk("m_valid", IW'(bus.m_valid), IW'(beats_left > 0));
        if (beats_left > 0) begin
            chk("m_last", IW'(bus.m_last), IW'(beats_left == 1));
            if (beats_left == 2) chk("m_data_b0", IW'(bus.m_data), IW'(cur[OW-1:0]));
            else                 chk("m_data_b1", IW'(bus.m_data), IW'(cur[IW-1:OW]));
        end
        chk("data_count", IW'(bus.data_count), IW'(sz));
        chk("full",       IW'(bus.full),       IW'(sz == DEPTH));
        chk("empty",      IW'(bus.empty),      IW'(sz == 0));
        chk("threshold",  IW'(bus.threshold),  IW'(sz >= DEPTH / 2));
        chk("overflow",   IW'(bus.overflow),   IW'(ovf_m));
    endtask

    // One clock: apply inputs, advance the model by the same edge, then compare.
    task automatic cycle(input bit w, input logic [IW-1:0] d, input bit r);
        bit was_empty, was_full, pop;
        bus.wr      = w;
        bus.data_in = d;
        bus.m_ready = r;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        pop       = !was_empty && (beats_left == 0 || (beats_left == 1 && r));
        if (beats_left > 0 && r) begin
            beats_left--;
            n_beats++;
        end
        if (pop) begin
            cur        = mq.pop_front();
            beats_left = 2;
        end
        if (w) begin
            if (was_full) ovf_m = 1'b1;
            else          mq.push_back(d);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.data_in = '0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        beats_left = 0;
        ovf_m      = 1'b0;
        chk("rst_m_valid",    IW'(bus.m_valid),    '0);
        chk("rst_m_last",     IW'(bus.m_last),     '0);
        chk("rst_m_data",     IW'(bus.m_data),     '0);
        chk("rst_empty",      IW'(bus.empty),      IW'(1));
        chk("rst_full",       IW'(bus.full),       '0);
        chk("rst_data_count", IW'(bus.data_count), '0);
        chk("rst_overflow",   IW'(bus.overflow),   '0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((mq.size() > 0 || beats_left > 0) && k < budget) begin
            cycle(1'b0, '0, 1'b1);
            k++;
        end
        chk("drain_done", IW'(k < budget), IW'(1));
    endtask

    logic [IW-1:0] single;
    logic [OW-1:0] held;
    logic [5:0]    lasts;
    int            start, written, c;

    initial begin
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.data_in = '0;
        bus.m_ready = 1'b0;
        beats_left  = 0;
        ovf_m       = 1'b0;
        n_beats     = 0;
        repeat (2) @(posedge clk);

        // Single entry: lane split and two-cycle first-beat latency.
        do_reset();
        single = {64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB};
        cycle(1'b1, single, 1'b1);
        chk("lat_wr_edge", IW'(bus.m_valid), '0);
        cycle(1'b0, '0, 1'b1);
        chk("single_b0", IW'(bus.m_data), IW'({64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB}));
        chk("single_b0_last", IW'(bus.m_last), '0);
        cycle(1'b0, '0, 1'b1);
        chk("single_b1", IW'(bus.m_data), IW'({64'h0, 64'h1111111111111111}));
        chk("single_b1_last", IW'(bus.m_last), IW'(1));
        cycle(1'b0, '0, 1'b1);
        chk("single_after_valid", IW'(bus.m_valid), '0);
        chk("single_after_count", IW'(bus.data_count), '0);

        // Backpressure: beat held, then six beats with no gaps.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_entry(), 1'b0);
        held = bus.m_data;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("bp_hold", IW'(bus.m_data), IW'(held));
        end
        start = n_beats;
        for (int i = 0; i < 6; i++) begin
            chk("bp_no_gap", IW'(bus.m_valid), IW'(1));
            lasts[i] = bus.m_last;
            cycle(1'b0, '0, 1'b1);
        end
        chk("bp_beats", IW'(n_beats - start), IW'(6));
        chk("bp_last_pattern", IW'(lasts), IW'(6'b101010));

        // Threshold boundary.
        do_reset();
        for (int i = 0; i < 511; i++) cycle(1'b1, rand_entry(), 1'b0);
        chk("thr_count_510", IW'(bus.data_count), IW'(510));
        chk("thr_low", IW'(bus.threshold), '0);
        for (int i = 0; i < 2; i++) cycle(1'b1, rand_entry(), 1'b0);
        chk("thr_count_512", IW'(bus.data_count), IW'(512));
        chk("thr_high", IW'(bus.threshold), IW'(1));

        // Fill to capacity, drop one, drain in order.
        do_reset();
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, IW'(i), 1'b0);
        chk("fill_count", IW'(bus.data_count), IW'(DEPTH));
        chk("fill_full", IW'(bus.full), IW'(1));
        chk("fill_no_ovf_yet", IW'(bus.overflow), '0);
        cycle(1'b1, IW'(DEPTH + 1), 1'b0);
        chk("fill_ovf", IW'(bus.overflow), IW'(1));
        chk("fill_count_after_drop", IW'(bus.data_count), IW'(DEPTH));
        start = n_beats;
        drain(3 * DEPTH);
        chk("fill_beats", IW'(n_beats - start), IW'(2 * (DEPTH + 1)));
        chk("fill_ovf_sticky", IW'(bus.overflow), IW'(1));

        // Reset while in the second beat with five entries buffered.
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_entry(), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("mid_in_beat1", IW'(bus.m_last), IW'(1));
        chk("mid_count", IW'(bus.data_count), IW'(5));
        do_reset();
        start = n_beats;
        cycle(1'b1, rand_entry(), 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        chk("mid_new_only", IW'(n_beats - start), IW'(2));

        // Pointer wrap with random backpressure at a bounded write rate.
        do_reset();
        start   = n_beats;
        written = 0;
        c       = 0;
        while (written < 3 * DEPTH && c < 40000) begin
            if ((c % 2) == 0 && $urandom_range(0, 1) == 1) begin
                cycle(1'b1, rand_entry(), $urandom_range(0, 3) != 0);
                written++;
            end else begin
                cycle(1'b0, '0, $urandom_range(0, 3) != 0);
            end
            c++;
        end
        chk("wrap_all_written", IW'(written), IW'(3 * DEPTH));
        drain(4 * DEPTH);
        chk("wrap_beats", IW'(n_beats - start), IW'(6 * DEPTH));
        chk("wrap_no_ovf", IW'(bus.overflow), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
